// File: rtl/ts_pkg.sv
// Shared definitions for the training-sequence scheduler and the TS generator:
// FSM state encoding, ordered-set type codes and framing symbols.
package ts_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ISSUE_SKP,
    ST_WAIT_SKP,
    ST_DONE
  } ts_state_e;

  localparam logic [1:0] OS_TS1  = 2'b00;
  localparam logic [1:0] OS_TS2  = 2'b01;
  localparam logic [1:0] OS_EIOS = 2'b10;
  localparam logic [1:0] OS_SKP  = 2'b11;

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_PAD = 8'hF7;

  function automatic logic os_type_requestable(input logic [1:0] t);
    return t != OS_SKP;
  endfunction

  function automatic logic os_type_takes_skp(input logic [1:0] t);
    return t != OS_EIOS;
  endfunction

endpackage

// File: rtl/ts_sched_timer.sv
// SKP spacing counter and gen_done watchdog for the TS scheduler.
// Both are down-counters with a terminal-count compare.
module ts_sched_timer
  import ts_pkg::*;
#(
  parameter int SKP_OS_INTERVAL = 8,
  parameter int GEN_TIMEOUT     = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic skp_load,
  input  logic os_done,
  input  logic wd_load,
  input  logic wd_run,
  output logic skp_due,
  output logic wd_expired
);

  localparam int SKP_W = $clog2(SKP_OS_INTERVAL + 1);
  localparam int WD_W  = $clog2(GEN_TIMEOUT + 1);

  localparam logic [SKP_W-1:0] SKP_INIT = SKP_W'(SKP_OS_INTERVAL);
  localparam logic [SKP_W-1:0] SKP_ONE  = SKP_W'(1);
  localparam logic [WD_W-1:0]  WD_INIT  = WD_W'(GEN_TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);

  logic [SKP_W-1:0] skp_left_q, skp_left_d;
  logic [WD_W-1:0]  wd_left_q, wd_left_d;

  always_comb begin
    skp_left_d = skp_left_q;
    if (skp_load) begin
      skp_left_d = SKP_INIT;
    end else if (os_done && (skp_left_q != '0)) begin
      skp_left_d = skp_left_q - SKP_ONE;
    end

    // Loaded on ts_start so the full window covers the whole wait state.
    wd_left_d = wd_left_q;
    if (wd_load) begin
      wd_left_d = WD_INIT;
    end else if (wd_run && (wd_left_q != '0)) begin
      wd_left_d = wd_left_q - WD_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skp_left_q <= '0;
      wd_left_q  <= '0;
    end else begin
      skp_left_q <= skp_left_d;
      wd_left_q  <= wd_left_d;
    end
  end

  assign skp_due    = (skp_left_q == SKP_ONE);
  assign wd_expired = wd_run && (wd_left_q == '0);

endmodule

// File: rtl/ts_sched.sv
// Ordered-set burst scheduler: issues TS1/TS2/EIOS sets to the generator,
// inserts SKP sets at a fixed spacing and supervises each set with a watchdog.
//
//   state        | meaning
//   ST_IDLE      | ready for a burst request
//   ST_ISSUE     | ts_start for a TS/EIOS set
//   ST_WAIT      | waiting for gen_done of a TS/EIOS set
//   ST_ISSUE_SKP | ts_start for a SKP set
//   ST_WAIT_SKP  | waiting for gen_done of a SKP set
//   ST_DONE      | burst_done pulse, back to idle
module ts_sched
  import ts_pkg::*;
#(
  parameter int SKP_OS_INTERVAL = 8,
  parameter int GEN_TIMEOUT     = 64,
  parameter int CNT_W           = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_type,
  input  logic [CNT_W-1:0] req_count,
  input  logic [7:0]       req_info,
  input  logic             speed,
  input  logic             abort,
  output logic [7:0]       ts_info,
  output logic             ts_start,
  output logic [1:0]       os_type,
  input  logic             gen_done,
  output logic             speed_o,
  output logic [CNT_W-1:0] sent_cnt,
  output logic             busy,
  output logic             burst_done,
  output logic             err_timeout
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ts_state_e        state_q, state_d;
  logic [1:0]       type_q, type_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       info_q, info_d;
  logic             speed_q, speed_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             err_q, err_d;
  logic             abort_q, abort_d;

  logic             abort_now;
  logic [CNT_W-1:0] sent_inc;
  logic             last_set;
  logic             skp_load, os_done, wd_load, wd_run;
  logic             skp_due, wd_expired;

  ts_sched_timer #(
    .SKP_OS_INTERVAL (SKP_OS_INTERVAL),
    .GEN_TIMEOUT     (GEN_TIMEOUT)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .skp_load   (skp_load),
    .os_done    (os_done),
    .wd_load    (wd_load),
    .wd_run     (wd_run),
    .skp_due    (skp_due),
    .wd_expired (wd_expired)
  );

  assign abort_now = abort_q | abort;
  assign sent_inc  = sent_q + CNT_ONE;
  // Compare against the unsaturated increment; count 0 means run until abort.
  assign last_set  = (count_q != '0) && (sent_inc == count_q);

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    count_d  = count_q;
    info_d   = info_q;
    speed_d  = speed_q;
    sent_d   = sent_q;
    err_d    = err_q;
    abort_d  = abort_q;
    skp_load = 1'b0;
    os_done  = 1'b0;
    wd_load  = 1'b0;
    wd_run   = 1'b0;

    if (state_q != ST_IDLE) begin
      abort_d = abort_now;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid && os_type_requestable(req_type)) begin
          type_d   = req_type;
          count_d  = req_count;
          info_d   = req_info;
          speed_d  = speed;
          sent_d   = '0;
          err_d    = 1'b0;
          abort_d  = 1'b0;
          skp_load = 1'b1;
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        wd_load = 1'b1;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        wd_run = 1'b1;
        if (gen_done) begin
          os_done = 1'b1;
          sent_d  = (&sent_q) ? sent_q : sent_inc;
          if (abort_now || last_set) begin
            state_d = ST_DONE;
          end else if (skp_due && os_type_takes_skp(type_q)) begin
            state_d = ST_ISSUE_SKP;
          end else begin
            state_d = ST_ISSUE;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_ISSUE_SKP: begin
        skp_load = 1'b1;
        wd_load  = 1'b1;
        state_d  = ST_WAIT_SKP;
      end

      ST_WAIT_SKP: begin
        wd_run = 1'b1;
        if (gen_done) begin
          state_d = abort_now ? ST_DONE : ST_ISSUE;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      type_q  <= OS_TS1;
      count_q <= '0;
      info_q  <= '0;
      speed_q <= 1'b0;
      sent_q  <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      count_q <= count_d;
      info_q  <= info_d;
      speed_q <= speed_d;
      sent_q  <= sent_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign ts_start    = (state_q == ST_ISSUE) || (state_q == ST_ISSUE_SKP);
  assign burst_done  = (state_q == ST_DONE);
  assign os_type     = ((state_q == ST_ISSUE_SKP) || (state_q == ST_WAIT_SKP)) ? OS_SKP : type_q;
  assign ts_info     = info_q;
  assign speed_o     = speed_q;
  assign sent_cnt    = sent_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_ts_sched.sv
// Self-checking bench for ts_sched: directed bursts, a responding generator
// model and a cycle-stamped reference model compared on every cycle.
module tb_ts_sched;

  localparam int CNT_W     = 11;
  localparam int SKP_INT   = 8;
  localparam int GEN_TO    = 64;
  localparam int SENT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_type;
  logic [CNT_W-1:0] req_count;
  logic [7:0]       req_info;
  logic             speed;
  logic             abort;
  logic [7:0]       ts_info;
  logic             ts_start;
  logic [1:0]       os_type;
  logic             gen_done = 1'b0;
  logic             speed_o;
  logic [CNT_W-1:0] sent_cnt;
  logic             busy;
  logic             burst_done;
  logic             err_timeout;

  ts_sched #(
    .SKP_OS_INTERVAL (SKP_INT),
    .GEN_TIMEOUT     (GEN_TO),
    .CNT_W           (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_type    (req_type),
    .req_count   (req_count),
    .req_info    (req_info),
    .speed       (speed),
    .abort       (abort),
    .ts_info     (ts_info),
    .ts_start    (ts_start),
    .os_type     (os_type),
    .gen_done    (gen_done),
    .speed_o     (speed_o),
    .sent_cnt    (sent_cnt),
    .busy        (busy),
    .burst_done  (burst_done),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Generator stand-in: answers each ts_start gen_delay cycles later unless held.
  int gen_delay = 16;
  bit gen_hold  = 1'b0;
  int pend_at   = -1;
  int spur_at   = -1;

  always @(negedge clk) begin
    if (rst) pend_at = -1;
    else if (ts_start && !gen_hold) pend_at = cyc + gen_delay;
  end

  always @(posedge clk) begin
    #1;
    gen_done = !rst && ((cyc == pend_at) || (cyc == spur_at));
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Observed pulse counters
  int ts_total = 0, skp_total = 0, data_total = 0, bd_total = 0;
  int skp_pos_q[$];

  // Reference model state, stamped with the cycle each event is due
  bit        m_active, m_err, m_abort, m_waiting, m_issue_skp, m_last;
  logic [1:0] m_type;
  logic [7:0] m_info;
  bit        m_speed;
  int        m_count, m_sent, m_since_skp;
  int        m_issue_cyc, m_done_cyc, m_wait_from;
  bit        exp_ts;

  task automatic model_reset();
    m_active = 0; m_err = 0; m_abort = 0; m_waiting = 0; m_issue_skp = 0;
    m_type = 2'b00; m_info = 8'h00; m_speed = 0;
    m_count = 0; m_sent = 0; m_since_skp = 0;
    m_issue_cyc = -1; m_done_cyc = -1; m_wait_from = 0;
  endtask

  task automatic model_step();
    if (!m_active) begin
      if (req_valid && req_type != 2'b11) begin
        m_active = 1; m_type = req_type; m_count = int'(req_count);
        m_info = req_info; m_speed = speed; m_sent = 0; m_err = 0;
        m_abort = 0; m_since_skp = 0; m_waiting = 0;
        m_issue_cyc = cyc + 1; m_issue_skp = 0; m_done_cyc = -1;
      end
    end else if (cyc == m_done_cyc) begin
      m_active = 0;
    end else begin
      if (abort) m_abort = 1;
      if (cyc == m_issue_cyc) begin
        m_waiting = 1;
        m_wait_from = cyc;
      end else if (m_waiting) begin
        if (gen_done) begin
          m_waiting = 0;
          if (m_issue_skp) begin
            if (m_abort) m_done_cyc = cyc + 1;
            else begin m_issue_cyc = cyc + 1; m_issue_skp = 0; end
          end else begin
            m_last = (m_count != 0) && (m_sent + 1 == m_count);
            m_sent = (m_sent + 1 > SENT_MAX) ? SENT_MAX : m_sent + 1;
            m_since_skp++;
            if (m_abort || m_last) m_done_cyc = cyc + 1;
            else if (m_since_skp == SKP_INT && m_type != 2'b10) begin
              m_issue_cyc = cyc + 1; m_issue_skp = 1; m_since_skp = 0;
            end else m_issue_cyc = cyc + 1;
          end
        end else if (cyc - m_wait_from == GEN_TO) begin
          m_waiting = 0; m_err = 1; m_done_cyc = cyc + 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [1:0] t, input int n, input logic [7:0] info,
                          input logic spd, output int acc);
    tick();
    req_valid = 1'b1; req_type = t; req_count = CNT_W'(n); req_info = info; speed = spd;
    acc = cyc;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (burst_done) begin dcyc = cyc; break; end
    end
    if (dcyc < 0) begin
      checks++; errors++;
      $display("FAIL burst_done_wait: none within %0d cycles", bound);
    end
  endtask

  task automatic wait_sets(input int target, input bit data_only, input int bound);
    bit hit;
    hit = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if ((data_only ? data_total : ts_total) >= target) begin hit = 1; break; end
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL ts_start_wait: count %0d not reached within %0d cycles", target, bound);
    end
  endtask

  int acc, dcyc, b_ts, b_skp, b_data, b_bd, b_pos;

  initial begin
    req_valid = 0; req_type = 0; req_count = 0; req_info = 0; speed = 0; abort = 0;
    model_reset();

    fork
      forever begin
        @(negedge clk);
        if (ts_start === 1'b1) begin
          ts_total++;
          if (os_type == 2'b11) begin skp_total++; skp_pos_q.push_back(ts_total); end
          else data_total++;
        end
        if (burst_done === 1'b1) bd_total++;
        if (rst) begin
          model_reset();
          chk("rst_busy", busy, 0);
          chk("rst_ready", req_ready, 1);
          chk("rst_ts_start", ts_start, 0);
          chk("rst_burst_done", burst_done, 0);
          chk("rst_sent_cnt", sent_cnt, 0);
          chk("rst_err_timeout", err_timeout, 0);
          chk("rst_ts_info", ts_info, 0);
          chk("rst_os_type", os_type, 0);
          chk("rst_speed_o", speed_o, 0);
        end else begin
          exp_ts = m_active && (cyc == m_issue_cyc);
          chk("ts_start", ts_start, exp_ts);
          if (exp_ts) chk("os_type", os_type, m_issue_skp ? 2'b11 : m_type);
          chk("busy", busy, m_active);
          chk("req_ready", req_ready, !m_active);
          chk("burst_done", burst_done, m_active && (cyc == m_done_cyc));
          chk("sent_cnt", sent_cnt, m_sent);
          chk("err_timeout", err_timeout, m_err);
          chk("ts_info", ts_info, m_info);
          chk("speed_o", speed_o, m_speed);
          model_step();
        end
      end
    join_none

    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    tick();
    chk("ready_after_rst", req_ready, 1);
    chk("busy_after_rst", busy, 0);

    // TS1 x3, generator answers 16 cycles after each ts_start
    gen_delay = 16;
    b_ts = ts_total; b_skp = skp_total; b_bd = bd_total;
    send_req(2'b00, 3, 8'h21, 1'b1, acc);
    wait_done(300, dcyc);
    chk("t1_latency", dcyc - acc, 52);
    chk("t1_ts_pulses", ts_total - b_ts, 3);
    chk("t1_skp", skp_total - b_skp, 0);
    chk("t1_sent", sent_cnt, 3);
    chk("t1_bd", bd_total - b_bd, 1);
    chk("t1_info", ts_info, 8'h21);
    chk("t1_speed", speed_o, 1);

    // Idle: reserved type, abort and a stray gen_done must all be ignored
    tick();
    b_ts = ts_total;
    spur_at = cyc + 2;
    req_valid = 1'b1; req_type = 2'b11; req_count = 5; abort = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    abort = 1'b0;
    repeat (4) tick();
    chk("rsvd_busy", busy, 0);
    chk("rsvd_ts_pulses", ts_total - b_ts, 0);

    // TS2 x20 with SKP after the 8th and 16th set
    gen_delay = 2;
    b_ts = ts_total; b_skp = skp_total; b_pos = skp_pos_q.size();
    send_req(2'b01, 20, 8'h42, 1'b0, acc);
    wait_done(400, dcyc);
    chk("t2_ts_pulses", ts_total - b_ts, 22);
    chk("t2_skp", skp_total - b_skp, 2);
    if (skp_pos_q.size() >= b_pos + 2) begin
      chk("t2_skp_pos1", skp_pos_q[b_pos] - b_ts, 9);
      chk("t2_skp_pos2", skp_pos_q[b_pos + 1] - b_ts, 18);
    end else begin
      checks++; errors++;
      $display("FAIL t2_skp_pos: only %0d SKP recorded, 2 required", skp_pos_q.size() - b_pos);
    end
    chk("t2_sent", sent_cnt, 20);

    // Continuous burst, abort while waiting on the 5th set
    gen_delay = 4;
    b_ts = ts_total;
    send_req(2'b00, 0, 8'h33, 1'b0, acc);
    wait_sets(b_ts + 5, 1'b0, 200);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(100, dcyc);
    chk("t3_sent", sent_cnt, 5);
    chk("t3_ts_pulses", ts_total - b_ts, 5);

    // Generator silent: watchdog ends the burst
    gen_hold = 1'b1;
    b_ts = ts_total;
    send_req(2'b00, 3, 8'h44, 1'b1, acc);
    wait_done(200, dcyc);
    chk("t4_latency", dcyc - acc, 66);
    chk("t4_err", err_timeout, 1);
    chk("t4_sent", sent_cnt, 0);
    chk("t4_ts_pulses", ts_total - b_ts, 1);
    repeat (3) tick();
    chk("t4_err_sticky", err_timeout, 1);

    // EIOS x10: clears the error on acceptance, never inserts SKP
    gen_hold = 1'b0;
    gen_delay = 1;
    b_ts = ts_total; b_skp = skp_total;
    send_req(2'b10, 10, 8'h55, 1'b0, acc);
    chk("t5_err_cleared", err_timeout, 0);
    wait_done(200, dcyc);
    chk("t5_skp", skp_total - b_skp, 0);
    chk("t5_ts_pulses", ts_total - b_ts, 10);
    chk("t5_sent", sent_cnt, 10);

    // sent_cnt saturation in a continuous burst
    gen_delay = 1;
    b_data = data_total;
    send_req(2'b01, 0, 8'h66, 1'b1, acc);
    wait_sets(b_data + SENT_MAX + 3, 1'b1, 20000);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(100, dcyc);
    chk("t6_sent_sat", sent_cnt, SENT_MAX);

    // Asynchronous reset in the middle of a wait
    gen_delay = 3;
    b_ts = ts_total;
    send_req(2'b01, 5, 8'h5A, 1'b1, acc);
    wait_sets(b_ts + 2, 1'b0, 100);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_ready", req_ready, 1);
    chk("ar_ts_start", ts_start, 0);
    chk("ar_burst_done", burst_done, 0);
    chk("ar_sent", sent_cnt, 0);
    chk("ar_info", ts_info, 0);
    chk("ar_os_type", os_type, 0);
    chk("ar_speed_o", speed_o, 0);
    chk("ar_err", err_timeout, 0);
    b_bd = bd_total;
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (30) tick();
    chk("ar_no_bd", bd_total - b_bd, 0);
    chk("ar_idle", busy, 0);

    // Single-set burst after reset recovery
    gen_delay = 2;
    send_req(2'b00, 1, 8'h77, 1'b0, acc);
    wait_done(100, dcyc);
    chk("t7_latency", dcyc - acc, 4);
    chk("t7_sent", sent_cnt, 1);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
